// File: rtl/pwm_serial_frame_gen.sv
// Multi-channel PWM generator feeding an external SIPO shift register with latch.
// One PWM step per serial frame; duty values double-buffered and swapped at period wrap.
module pwm_serial_frame_gen #(
  parameter int CHANNELS  = 8,
  parameter int CNT_WIDTH = 8,
  parameter int PERIOD    = 100,
  parameter int INVERT    = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        duty_we,
  input  logic [$clog2(CHANNELS)-1:0] duty_addr,
  input  logic [CNT_WIDTH-1:0]        duty_data,
  output logic                        ser_data,
  output logic                        ser_shift,
  output logic                        ser_latch,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        period_start
);

  localparam int                   AW        = $clog2(CHANNELS);
  localparam logic                 INV       = (INVERT != 0);
  localparam logic [AW-1:0]        LAST_IDX  = AW'(CHANNELS - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                state, state_nx;
  logic [AW-1:0]         idx, idx_nx;
  logic [CNT_WIDTH-1:0]  step;
  logic [CNT_WIDTH-1:0]  staging [CHANNELS];
  logic [CNT_WIDTH-1:0]  shadow  [CHANNELS];
  logic [CHANNELS-1:0]   frame;

  logic                  ser_data_nx, ser_shift_nx, ser_latch_nx, period_start_nx;
  logic [CHANNELS-1:0]   pwm_out_nx;

  // Step and shadows are frozen for a whole frame, so every shifted bit comes from one step.
  always_comb begin
    frame = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      frame[k] = (step < shadow[k]) ^ INV;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nx = SHIFT;
          idx_nx   = LAST_IDX;
        end
      end
      SHIFT: begin
        if (idx == '0) state_nx = LATCH;
        else           idx_nx   = idx - 1'b1;
      end
      LATCH: begin
        if (enable) begin
          state_nx = SHIFT;
          idx_nx   = LAST_IDX;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered one cycle behind the state that produces them.
  always_comb begin
    ser_shift_nx    = (state == SHIFT);
    ser_latch_nx    = (state == LATCH);
    ser_data_nx     = ser_data;
    pwm_out_nx      = pwm_out;
    period_start_nx = 1'b0;
    if (state == SHIFT) ser_data_nx = frame[idx];
    if (state == LATCH) begin
      pwm_out_nx      = frame;
      period_start_nx = (step == '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ser_data     <= 1'b0;
      ser_shift    <= 1'b0;
      ser_latch    <= 1'b0;
      pwm_out      <= {CHANNELS{INV}};
      period_start <= 1'b0;
    end else begin
      ser_data     <= ser_data_nx;
      ser_shift    <= ser_shift_nx;
      ser_latch    <= ser_latch_nx;
      pwm_out      <= pwm_out_nx;
      period_start <= period_start_nx;
    end
  end

  // Shadow load uses the staging value from before any write landing on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step <= '0;
      for (int k = 0; k < CHANNELS; k++) shadow[k] <= '0;
    end else if (state == LATCH) begin
      if (step == LAST_STEP) begin
        step <= '0;
        for (int k = 0; k < CHANNELS; k++) shadow[k] <= staging[k];
      end else begin
        step <= step + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CHANNELS; k++) staging[k] <= '0;
    end else if (duty_we && (int'(duty_addr) < CHANNELS)) begin
      staging[duty_addr] <= duty_data;
    end
  end

endmodule
